// File: rtl/tsu_pkg.sv
// Shared definitions for the tsu_queue read side: register map, entry layout, reader FSM states.
package tsu_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_TS     = 2'd1;
    localparam logic [1:0] ADDR_INFO   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int TS_W      = 32;
    localparam int SEQID_W   = 16;
    localparam int MSG_W     = 8;
    localparam int ENTRY_W   = TS_W + SEQID_W + MSG_W;
    localparam int TS_LSB    = 0;
    localparam int SEQID_LSB = TS_W;
    localparam int MSG_LSB   = TS_W + SEQID_W;

    typedef enum logic [2:0] {
        ST_GUARD = 3'd0,
        ST_IDLE  = 3'd1,
        ST_POP   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } rd_state_e;

endpackage

// File: rtl/tsu_queue_reader_regs.sv
// Host read-only register window over the holding slot: read mux, ack flop and release decode.
module tsu_queue_reader_regs
    import tsu_pkg::*;
(
    input  logic               q_rd_clk,
    input  logic               q_rd_rst_n,
    input  logic               cpu_rd_en,
    input  logic [1:0]         cpu_rd_addr,
    input  logic [ENTRY_W-1:0] hold_data,
    input  logic               hold_valid,
    input  logic [7:0]         q_rd_stat,
    input  logic [31:0]        pop_count,
    input  logic               irq_stat,
    output logic [31:0]        cpu_rd_data,
    output logic               cpu_rd_ack,
    output logic               release_req
);

    logic [31:0] rd_mux;

    // Reading INFO on a live entry hands it back to the reader.
    assign release_req = cpu_rd_en && (cpu_rd_addr == ADDR_INFO) && hold_valid;

    always_comb begin
        rd_mux = '0;
        case (cpu_rd_addr)
            ADDR_STATUS: rd_mux = {16'h0000, q_rd_stat, 6'b000000, irq_stat, hold_valid};
            ADDR_TS:     rd_mux = hold_data[TS_LSB +: TS_W];
            ADDR_INFO:   if (hold_valid) rd_mux = {8'h00, hold_data[ENTRY_W-1:SEQID_LSB]};
            ADDR_COUNT:  rd_mux = pop_count;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge q_rd_clk or negedge q_rd_rst_n) begin
        if (!q_rd_rst_n) begin
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            cpu_rd_ack <= cpu_rd_en;
            if (cpu_rd_en) cpu_rd_data <= rd_mux;
        end
    end

endmodule

// File: rtl/tsu_queue_reader.sv
// Drains tsu_queue entries one at a time into a holding slot for the host.
// Optional macro TSU_RD_IRQ_EN adds the irq output (hold_valid delayed one cycle).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_GUARD | let queue status settle after reset/release
//   ST_IDLE  | wait for a non-empty queue
//   ST_POP   | one-cycle q_rd_en strobe
//   ST_WAIT  | count down read latency, capture entry at terminal count
//   ST_HOLD  | entry live for the host until the INFO read releases it
module tsu_queue_reader
    import tsu_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int STAT_GUARD = 2,
    parameter int CNT_W      = 16
)
(
    input  logic               q_rd_clk,
    input  logic               q_rd_rst_n,
    input  logic [7:0]         q_rd_stat,
    input  logic [ENTRY_W-1:0] q_rd_data,
    output logic               q_rd_en,
    input  logic               cpu_rd_en,
    input  logic [1:0]         cpu_rd_addr,
    output logic [31:0]        cpu_rd_data,
    output logic               cpu_rd_ack
`ifdef TSU_RD_IRQ_EN
    ,
    output logic               irq
`endif
);

    rd_state_e          state, state_nxt;
    logic [7:0]         guard_cnt, guard_nxt;
    logic [1:0]         lat_cnt, lat_nxt;
    logic               capture;
    logic [ENTRY_W-1:0] hold;
    logic               hold_valid;
    logic [CNT_W-1:0]   pop_cnt;
    logic               release_req;
    logic               irq_stat;

    always_comb begin
        state_nxt = state;
        guard_nxt = guard_cnt;
        lat_nxt   = lat_cnt;
        capture   = 1'b0;
        case (state)
            ST_GUARD: begin
                if (guard_cnt <= 8'd1) begin
                    guard_nxt = 8'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    guard_nxt = guard_cnt - 8'd1;
                end
            end
            ST_IDLE: begin
                if (q_rd_stat != 8'd0) state_nxt = ST_POP;
            end
            ST_POP: begin
                lat_nxt   = 2'(RD_LATENCY);
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt <= 2'd1) begin
                    lat_nxt   = 2'd0;
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end else begin
                    lat_nxt = lat_cnt - 2'd1;
                end
            end
            ST_HOLD: begin
                if (release_req) begin
                    guard_nxt = 8'(STAT_GUARD);
                    state_nxt = ST_GUARD;
                end
            end
            default: begin
                guard_nxt = 8'(STAT_GUARD);
                state_nxt = ST_GUARD;
            end
        endcase
    end

    assign q_rd_en = (state == ST_POP);

    always_ff @(posedge q_rd_clk or negedge q_rd_rst_n) begin
        if (!q_rd_rst_n) begin
            state      <= ST_GUARD;
            guard_cnt  <= 8'(STAT_GUARD);
            lat_cnt    <= 2'd0;
            hold       <= '0;
            hold_valid <= 1'b0;
            pop_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            guard_cnt <= guard_nxt;
            lat_cnt   <= lat_nxt;
            if (capture) begin
                hold       <= q_rd_data;
                hold_valid <= 1'b1;
                pop_cnt    <= pop_cnt + 1'b1;
            end else if (state == ST_HOLD && release_req) begin
                hold_valid <= 1'b0;
            end
        end
    end

`ifdef TSU_RD_IRQ_EN
    always_ff @(posedge q_rd_clk or negedge q_rd_rst_n) begin
        if (!q_rd_rst_n) irq <= 1'b0;
        else             irq <= hold_valid;
    end
    assign irq_stat = irq;
`else
    assign irq_stat = 1'b0;
`endif

    tsu_queue_reader_regs u_regs (
        .q_rd_clk    (q_rd_clk),
        .q_rd_rst_n  (q_rd_rst_n),
        .cpu_rd_en   (cpu_rd_en),
        .cpu_rd_addr (cpu_rd_addr),
        .hold_data   (hold),
        .hold_valid  (hold_valid),
        .q_rd_stat   (q_rd_stat),
        .pop_count   (32'(pop_cnt)),
        .irq_stat    (irq_stat),
        .cpu_rd_data (cpu_rd_data),
        .cpu_rd_ack  (cpu_rd_ack),
        .release_req (release_req)
    );

endmodule
